// File: rtl/calc_pkg.sv
// Shared constants for the calculator entry path.
//   - Keycodes produced by keypad_encoder for the non-digit keys.
//   - Operator encodings, also driven on op_code.
//   - FSM state encodings for calc_entry_fsm.
//   - Small key-classification helpers.
package calc_pkg;

  typedef logic [1:0] op_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_CLR = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  localparam op_t OP_NONE = 2'b00;
  localparam op_t OP_ADD  = 2'b01;
  localparam op_t OP_SUB  = 2'b10;
  localparam op_t OP_MUL  = 2'b11;

  localparam logic [2:0] ENTER_A     = 3'd0;
  localparam logic [2:0] OP_WAIT     = 3'd1;
  localparam logic [2:0] ENTER_B     = 3'd2;
  localparam logic [2:0] COMPUTE     = 3'd3;
  localparam logic [2:0] MUL         = 3'd4;
  localparam logic [2:0] SHOW_RESULT = 3'd5;

  function automatic logic is_digit(logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(logic [3:0] k);
    return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
  endfunction

  function automatic op_t key_to_op(logic [3:0] k);
    op_t op;
    case (k)
      KEY_ADD: op = OP_ADD;
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_entry_fsm_if.sv
// Keypad-to-display bundle for calc_entry_fsm.
//   key_pressed   : level from keypad_poller, high while a key is held
//   keycode       : keypad_encoder code, valid while key_pressed is high
//   display_value : binary value for bin2bcd_10bit
//   op_code       : pending operator (00 none, 01 add, 10 sub, 11 mul)
//   busy          : multiply in progress
//   error         : last result saturated
// master = keypad side, slave = calculator.
interface calc_entry_fsm_if
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 10
);
  logic             key_pressed;
  logic [3:0]       keycode;
  logic [WIDTH-1:0] display_value;
  op_t              op_code;
  logic             busy;
  logic             error;

  modport master (
    output key_pressed, keycode,
    input  display_value, op_code, busy, error
  );

  modport slave (
    input  key_pressed, keycode,
    output display_value, op_code, busy, error
  );
endinterface

// File: rtl/shift_add_mul.sv
// Sequential shift-add multiplier.
//   clk, reset : clock, asynchronous active-low reset
//   start      : one-cycle pulse, samples a and b
//   abort      : cancels any multiply in flight (no done pulse)
//   a, b       : WIDTH-bit unsigned operands
//   done       : one-cycle pulse WIDTH cycles after start; product valid with it
//   product    : 2*WIDTH-bit result
module shift_add_mul #(
  parameter int unsigned WIDTH = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               done_q;

  // Bit 0 is folded into the start cycle so the last partial product lands
  // on the same edge that raises done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else if (abort) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        acc_q    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
        mcand_q  <= {{(WIDTH - 1){1'b0}}, a, 1'b0};
        mplier_q <= b >> 1;
        cnt_q    <= CW'(WIDTH - 1);
        done_q   <= (WIDTH == 1);
      end else if (cnt_q != '0) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
        done_q   <= (cnt_q == CW'(1));
      end
    end
  end

  assign done    = done_q;
  assign product = acc_q;
endmodule

// File: rtl/calc_entry_fsm.sv
// Calculator entry FSM: turns keypad events into decimal operands, applies
// + - x =, and drives the binary value shown on the 3-digit display.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : key_pressed/keycode in; display_value/op_code/busy/error out
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned MAX_VALUE = 999
) (
  input logic             clk,
  input logic             reset,
  calc_entry_fsm_if.slave bus
);
  localparam int unsigned EW = WIDTH + 4;  // holds value*10 + 9

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  op_t              op_q, op_d, next_op_q, next_op_d;
  logic             chain_q, chain_d, error_q, error_d, key_prev_q;

  logic key_evt, key_clr, key_digit, key_op, key_eq;
  assign key_evt   = bus.key_pressed & ~key_prev_q;
  assign key_clr   = key_evt && (bus.keycode == KEY_CLR);
  assign key_digit = is_digit(bus.keycode);
  assign key_op    = is_op(bus.keycode);
  assign key_eq    = bus.keycode == KEY_EQ;

  logic [EW-1:0] app_a, app_b;
  logic          fits_a, fits_b;
  assign app_a  = EW'(a_q) * EW'(10) + EW'(bus.keycode);
  assign app_b  = EW'(b_q) * EW'(10) + EW'(bus.keycode);
  assign fits_a = app_a <= EW'(MAX_VALUE);
  assign fits_b = app_b <= EW'(MAX_VALUE);

  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] product;
  assign mul_start = (state_q == COMPUTE) && (op_q == OP_MUL);

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .abort  (key_clr),
    .a      (a_q),
    .b      (b_q),
    .done   (mul_done),
    .product(product)
  );

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_val;
  logic             res_err, res_load;
  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign res_load = ((state_q == COMPUTE) && (op_q != OP_MUL)) || ((state_q == MUL) && mul_done);

  always_comb begin
    res_val = a_q;
    res_err = 1'b0;
    case (op_q)
      OP_ADD: begin
        if (sum > (WIDTH + 1)'(MAX_VALUE)) begin
          res_val = WIDTH'(MAX_VALUE);
          res_err = 1'b1;
        end else begin
          res_val = sum[WIDTH-1:0];
        end
      end
      OP_SUB: begin
        if (b_q > a_q) begin
          res_val = '0;
          res_err = 1'b1;
        end else begin
          res_val = a_q - b_q;
        end
      end
      OP_MUL: begin
        if (product > (2 * WIDTH)'(MAX_VALUE)) begin
          res_val = WIDTH'(MAX_VALUE);
          res_err = 1'b1;
        end else begin
          res_val = product[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    next_op_d = next_op_q;
    chain_d   = chain_q;
    error_d   = error_q;
    // Clear beats everything, including a multiplier done in the same cycle.
    if (key_clr) begin
      state_d   = ENTER_A;
      a_d       = '0;
      b_d       = '0;
      op_d      = OP_NONE;
      next_op_d = OP_NONE;
      chain_d   = 1'b0;
      error_d   = 1'b0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (key_evt && key_digit) begin
            if (fits_a) a_d = app_a[WIDTH-1:0];
          end else if (key_evt && key_op) begin
            op_d    = key_to_op(bus.keycode);
            state_d = OP_WAIT;
          end
        end
        OP_WAIT: begin
          if (key_evt && key_digit) begin
            b_d     = WIDTH'(bus.keycode);
            state_d = ENTER_B;
          end else if (key_evt && key_op) begin
            op_d = key_to_op(bus.keycode);
          end
        end
        ENTER_B: begin
          if (key_evt && key_digit) begin
            if (fits_b) b_d = app_b[WIDTH-1:0];
          end else if (key_evt && key_eq) begin
            chain_d = 1'b0;
            state_d = COMPUTE;
          end else if (key_evt && key_op) begin
            chain_d   = 1'b1;
            next_op_d = key_to_op(bus.keycode);
            state_d   = COMPUTE;
          end
        end
        COMPUTE: begin
          if (op_q == OP_MUL) state_d = MUL;
        end
        MUL: begin
        end
        SHOW_RESULT: begin
          if (key_evt && key_digit) begin
            a_d     = WIDTH'(bus.keycode);
            error_d = 1'b0;
            op_d    = OP_NONE;
            state_d = ENTER_A;
          end else if (key_evt && key_op) begin
            op_d    = key_to_op(bus.keycode);
            state_d = OP_WAIT;
          end
        end
        default: state_d = ENTER_A;
      endcase

      if (res_load) begin
        a_d     = res_val;
        error_d = res_err;
        if (chain_q) begin
          op_d    = next_op_q;
          chain_d = 1'b0;
          state_d = OP_WAIT;
        end else begin
          state_d = SHOW_RESULT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ENTER_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_NONE;
      next_op_q  <= OP_NONE;
      chain_q    <= 1'b0;
      error_q    <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      next_op_q  <= next_op_d;
      chain_q    <= chain_d;
      error_q    <= error_d;
      key_prev_q <= bus.key_pressed;
    end
  end

  assign bus.display_value = (state_q == ENTER_B) ? b_q : a_q;
  assign bus.op_code       = op_q;
  assign bus.busy          = mul_start || (state_q == MUL);
  assign bus.error         = error_q;
endmodule

// File: tb/tb_calc_entry_fsm.sv
module tb_calc_entry_fsm;
  localparam int unsigned W = 10;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  calc_entry_fsm_if #(.WIDTH(W)) intf ();

  calc_entry_fsm #(.WIDTH(W), .MAX_VALUE(999)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (intf)
  );

  typedef struct {
    int    cyc;
    bit    full;
    int    disp;
    int    op;
    bit    busy;
    bit    err;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural calculator: what the user would see on the display.
  typedef enum int {MdA, MdOpWait, MdB, MdResult} mode_e;
  mode_e mode;
  int    ma, mb, mop;
  bit    merr;
  int    last_c;

  task automatic model_reset();
    mode = MdA; ma = 0; mb = 0; mop = 0; merr = 1'b0;
  endtask

  function automatic int model_disp();
    return (mode == MdB) ? mb : ma;
  endfunction

  task automatic compute(input bit chained, input int opk, output int lat);
    int r;
    case (mop)
      1:       r = ma + mb;
      2:       r = ma - mb;
      default: r = ma * mb;
    endcase
    merr = (r > 999) || (r < 0);
    ma   = (r > 999) ? 999 : ((r < 0) ? 0 : r);
    lat  = (mop == 3) ? 12 : 2;
    if (chained) begin
      mop  = opk;
      mode = MdOpWait;
    end else begin
      mode = MdResult;
    end
  endtask

  task automatic model_key(input logic [3:0] k, output int lat);
    int d;
    d   = int'(k);
    lat = 1;
    if (d == 13) begin
      model_reset();
    end else if (d <= 9) begin
      case (mode)
        MdA:      if (ma * 10 + d <= 999) ma = ma * 10 + d;
        MdOpWait: begin mb = d; mode = MdB; end
        MdB:      if (mb * 10 + d <= 999) mb = mb * 10 + d;
        default:  begin ma = d; merr = 1'b0; mop = 0; mode = MdA; end
      endcase
    end else if (d >= 10 && d <= 12) begin
      if (mode == MdB) compute(1'b1, d - 9, lat);
      else begin
        mop  = d - 9;
        mode = MdOpWait;
      end
    end else if (d == 15 && mode == MdB) begin
      compute(1'b0, 0, lat);
    end
  endtask

  // Insert in cycle order so the monitor only ever looks at the front.
  task automatic push(input int at, input bit full, input bit busy, input string name);
    exp_t e;
    int   i;
    e.cyc = at; e.full = full; e.disp = model_disp(); e.op = mop;
    e.busy = busy; e.err = merr; e.name = name;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= at) i++;
    sb.insert(i, e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called on a negedge; key is registered on the following posedge.
  task automatic press(input logic [3:0] k, input int hold, input bit wait_done);
    int c, lat, t;
    c      = cyc;
    last_c = c;
    intf.keycode     = k;
    intf.key_pressed = 1'b1;
    if (k == 4'hD) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].cyc > c) sb.delete(i);
    end
    model_key(k, lat);
    if (lat == 12) begin
      push(c + 1, 1'b0, 1'b1, "busy_start");
      push(c + 11, 1'b0, 1'b1, "busy_end");
    end else if (lat == 2) begin
      push(c + 1, 1'b0, 1'b0, "busy_addsub");
    end
    push(c + lat, 1'b1, 1'b0, $sformatf("key_%h", k));
    repeat (hold) @(negedge clk);
    intf.key_pressed = 1'b0;
    intf.keycode     = 4'($urandom);
    if (wait_done) begin
      t = (c + hold + 1 > c + lat) ? c + hold + 1 : c + lat;
      wait_until(t);
    end
  endtask

  task automatic press_drop(input logic [3:0] k);
    intf.keycode     = k;
    intf.key_pressed = 1'b1;
    repeat (2) @(negedge clk);
    intf.key_pressed = 1'b0;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      automatic exp_t e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: check for cycle %0d reached only at cycle %0d", e.name, e.cyc, cyc);
      end else if (e.full) begin
        if (int'(intf.display_value) != e.disp || int'(intf.op_code) != e.op ||
            intf.busy != e.busy || intf.error != e.err) begin
          failures++;
          $display("FAIL %s @%0d: got disp=%0d op=%0d busy=%0b err=%0b, want disp=%0d op=%0d busy=%0b err=%0b",
                   e.name, cyc, intf.display_value, intf.op_code, intf.busy, intf.error,
                   e.disp, e.op, e.busy, e.err);
        end
      end else if (intf.busy != e.busy) begin
        failures++;
        $display("FAIL %s @%0d: got busy=%0b, want busy=%0b", e.name, cyc, intf.busy, e.busy);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] k;
    int r;
    reset = 1'b0;
    intf.key_pressed = 1'b0;
    intf.keycode = 4'h0;
    model_reset();
    @(negedge clk);
    push(cyc + 1, 1'b1, 1'b0, "reset_state");
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // 1,2,3 then 4 overflows
    press(4'h1, 1, 1); press(4'h2, 2, 1); press(4'h3, 1, 1); press(4'h4, 1, 1);
    // 123 + 77 =
    press(4'hA, 1, 1); press(4'h7, 1, 1); press(4'h7, 1, 1); press(4'hF, 1, 1);
    press(4'hF, 1, 1);
    // 5 - 9 = saturates at 0, then new entry
    press(4'h5, 1, 1); press(4'hB, 1, 1); press(4'h9, 1, 1); press(4'hF, 1, 1);
    press(4'h7, 1, 1);
    // 40 x 25 = 999 with a dropped key while busy
    press(4'hD, 1, 1); press(4'h4, 1, 1); press(4'h0, 1, 1); press(4'hC, 1, 1);
    press(4'h2, 1, 1); press(4'h5, 1, 1); press(4'hF, 1, 0);
    wait_until(last_c + 3);
    r = last_c;
    press_drop(4'h3);
    wait_until(r + 13);
    // Clear during multiply
    press(4'hD, 1, 1); press(4'h4, 1, 1); press(4'h0, 1, 1); press(4'hC, 1, 1);
    press(4'h2, 1, 1); press(4'h5, 1, 1); press(4'hF, 1, 0);
    wait_until(last_c + 5);
    press(4'hD, 1, 1);
    repeat (15) @(negedge clk);
    push(cyc + 1, 1'b1, 1'b0, "after_abort");
    @(negedge clk); @(negedge clk);
    // Chain: 2 + 3 x 4 =
    press(4'h2, 1, 1); press(4'hA, 1, 1); press(4'h3, 1, 1); press(4'hC, 1, 1);
    press(4'h4, 1, 1); press(4'hF, 1, 1);
    // Long hold yields one event
    press(4'hD, 1, 1); press(4'h7, 1000, 1);
    push(cyc + 1, 1'b1, 1'b0, "after_hold");
    @(negedge clk); @(negedge clk);

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      k = 4'($urandom_range(0, 9));
      else if (r < 75) k = 4'($urandom_range(10, 12));
      else if (r < 88) k = 4'hF;
      else if (r < 93) k = 4'hE;
      else             k = 4'hD;
      press(k, $urandom_range(1, 4), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Async reset mid-entry
    press(4'hD, 1, 1); press(4'h4, 1, 1); press(4'h5, 1, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    push(cyc, 1'b1, 1'b0, "async_reset");
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    push(cyc + 1, 1'b1, 1'b0, "post_reset");
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
